// File: rtl/ledr_ctrl.sv
// Memory-mapped LED controller: data register with set/clear aliases, per-LED
// blink mask and a programmable blink half-period, decoded in a six-word window.
module ledr_ctrl #(
  parameter int          BITS     = 32,
  parameter int          LED_BITS = 10,
  parameter int          CNT_BITS = 24,
  parameter logic [31:0] BASE     = 32'hFFFFF020
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BITS-1:0]     ABUS,
  inout  wire  [BITS-1:0]     DBUS,
  input  logic                WE,
  output logic [LED_BITS-1:0] LEDR
);

  localparam logic [BITS-1:0] A_LDATA   = BITS'(BASE);
  localparam logic [BITS-1:0] A_LSET    = BITS'(BASE + 32'd4);
  localparam logic [BITS-1:0] A_LCLR    = BITS'(BASE + 32'd8);
  localparam logic [BITS-1:0] A_LMODE   = BITS'(BASE + 32'd12);
  localparam logic [BITS-1:0] A_LPERIOD = BITS'(BASE + 32'd16);
  localparam logic [BITS-1:0] A_LOUT    = BITS'(BASE + 32'd20);

  logic [LED_BITS-1:0] ldata;
  logic [LED_BITS-1:0] lmode;
  logic [CNT_BITS-1:0] lperiod;
  logic [CNT_BITS-1:0] cnt;
  logic                phase;

  logic sel_ldata, sel_lset, sel_lclr, sel_lmode, sel_lperiod, sel_lout;
  logic any_sel;
  logic wr_ldata, wr_lset, wr_lclr, wr_lmode, wr_lperiod;
  logic rd_en;
  logic [BITS-1:0] rd_data;
  logic [LED_BITS-1:0] wdata_led;
  logic [CNT_BITS-1:0] wdata_cnt;
  logic unused_dbus;

  // Full-width equality decode: misaligned or out-of-window addresses select nothing.
  assign sel_ldata   = (ABUS == A_LDATA);
  assign sel_lset    = (ABUS == A_LSET);
  assign sel_lclr    = (ABUS == A_LCLR);
  assign sel_lmode   = (ABUS == A_LMODE);
  assign sel_lperiod = (ABUS == A_LPERIOD);
  assign sel_lout    = (ABUS == A_LOUT);
  assign any_sel     = sel_ldata | sel_lset | sel_lclr | sel_lmode | sel_lperiod | sel_lout;

  assign wr_ldata   = WE & sel_ldata;
  assign wr_lset    = WE & sel_lset;
  assign wr_lclr    = WE & sel_lclr;
  assign wr_lmode   = WE & sel_lmode;
  assign wr_lperiod = WE & sel_lperiod;

  assign wdata_led   = DBUS[LED_BITS-1:0];
  assign wdata_cnt   = DBUS[CNT_BITS-1:0];
  assign unused_dbus = ^DBUS;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ldata   <= '0;
      lmode   <= '0;
      lperiod <= '0;
    end else begin
      if (wr_ldata)   ldata   <= wdata_led;
      if (wr_lset)    ldata   <= ldata | wdata_led;
      if (wr_lclr)    ldata   <= ldata & ~wdata_led;
      if (wr_lmode)   lmode   <= wdata_led;
      if (wr_lperiod) lperiod <= wdata_cnt;
    end
  end

  // Blink engine: wrapping at lperiod-1 gives a half-period of exactly lperiod cycles.
  always_ff @(posedge CLK) begin
    if (RST || wr_lperiod || wr_lmode) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (lperiod == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == lperiod - CNT_BITS'(1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) LEDR <= '0;
    else     LEDR <= ldata & (~lmode | {LED_BITS{phase}});
  end

  always_comb begin
    rd_data = '0;
    if (sel_ldata)   rd_data[LED_BITS-1:0] = ldata;
    if (sel_lmode)   rd_data[LED_BITS-1:0] = lmode;
    if (sel_lperiod) rd_data[CNT_BITS-1:0] = lperiod;
    if (sel_lout)    rd_data[LED_BITS-1:0] = LEDR;
  end

  // The bus is driven only for a decoded read; set/clear aliases read back as 0.
  assign rd_en = ~WE & any_sel;
  assign DBUS  = rd_en ? rd_data : {BITS{1'bz}};

endmodule

// File: tb/tb_ledr_ctrl.sv
// Self-checking bench for ledr_ctrl: directed scenarios then random bus traffic,
// compared against a time-based behavioural model of the blink and register map.
module tb_ledr_ctrl;

  localparam int          BITS     = 32;
  localparam int          LED_BITS = 10;
  localparam int          CNT_BITS = 24;
  localparam logic [31:0] BASE     = 32'hFFFFF020;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] abus;
  logic [31:0] drv;
  logic        oe;
  wire  [31:0] dbus;
  logic [9:0]  ledr;

  assign dbus = oe ? drv : {32{1'bz}};

  ledr_ctrl #(
    .BITS(BITS), .LED_BITS(LED_BITS), .CNT_BITS(CNT_BITS), .BASE(BASE)
  ) dut (
    .CLK(clk), .RST(rst), .ABUS(abus), .DBUS(dbus), .WE(we), .LEDR(ledr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model: phase derived from edges elapsed since the last restart
  logic [9:0]  m_ldata  = '0;
  logic [9:0]  m_lmode  = '0;
  logic [23:0] m_period = '0;
  logic [9:0]  m_ledr   = '0;
  longint      edge_n   = 0;
  longint      restart  = 0;

  function automatic logic m_phase();
    if (m_period == 0) return 1'b1;
    return (((edge_n - restart) / longint'(m_period)) % 2) == 0;
  endfunction

  function automatic bit mapped(input logic [31:0] a);
    return (a == BASE) || (a == BASE + 32'd4) || (a == BASE + 32'd8) ||
           (a == BASE + 32'd12) || (a == BASE + 32'd16) || (a == BASE + 32'd20);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == BASE)          return {22'b0, m_ldata};
    if (a == BASE + 32'd12) return {22'b0, m_lmode};
    if (a == BASE + 32'd16) return {8'b0, m_period};
    if (a == BASE + 32'd20) return {22'b0, m_ledr};
    return 32'd0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // one bus cycle: drive at negedge, check read data, advance model at posedge, check LEDR
  task automatic cycle(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
    logic [9:0] nl;
    @(negedge clk);
    rst = r; we = w; abus = a; drv = d; oe = w;
    #1;
    if (!w) begin
      if (mapped(a)) check_val({tag, "_rd"}, dbus, m_read(a));
      else check_val({tag, "_hiz"}, {31'b0, (dbus === {32{1'bz}}) || (dbus === 32'd0)}, 32'd1);
    end
    @(posedge clk);
    nl = m_ldata & (~m_lmode | {10{m_phase()}});
    edge_n++;
    if (r) begin
      m_ldata = '0; m_lmode = '0; m_period = '0; m_ledr = '0; restart = edge_n;
    end else begin
      m_ledr = nl;
      if (w) begin
        if (a == BASE)          m_ldata = d[9:0];
        if (a == BASE + 32'd4)  m_ldata = m_ldata | d[9:0];
        if (a == BASE + 32'd8)  m_ldata = m_ldata & ~d[9:0];
        if (a == BASE + 32'd12) begin m_lmode  = d[9:0];  restart = edge_n; end
        if (a == BASE + 32'd16) begin m_period = d[23:0]; restart = edge_n; end
      end
    end
    #1;
    check_val({tag, "_ledr"}, {22'b0, ledr}, {22'b0, m_ledr});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
    cycle(1'b0, 1'b1, a, d, tag);
  endtask

  task automatic rd(input logic [31:0] a, input string tag);
    cycle(1'b0, 1'b0, a, 32'd0, tag);
  endtask

  initial begin
    logic [31:0] a, d, rnd;
    int sel;
    rst = 1'b1; we = 1'b0; abus = 32'd0; drv = 32'd0; oe = 1'b0;

    // reset and readback
    cycle(1'b1, 1'b0, 32'd0, 32'd0, "rst0");
    cycle(1'b1, 1'b0, BASE, 32'd0, "rst1");
    for (int i = 0; i < 6; i++) rd(BASE + 32'(4 * i), "rst_rd");
    rd(BASE + 32'd24, "unmapped");

    // static write, upper bits ignored
    wr(BASE, 32'hFFFF_F3A5, "static_wr");
    rd(BASE, "static_rd");
    rd(BASE + 32'd20, "static_lout");
    rd(BASE + 32'd24, "unmapped_busy");
    rd(BASE + 32'd1, "misaligned");

    // set / clear aliases
    wr(BASE, 32'h00F, "sc_data");
    wr(BASE + 32'd4, 32'h300, "sc_set");
    wr(BASE + 32'd8, 32'h003, "sc_clr");
    rd(BASE, "sc_rd");
    rd(BASE + 32'd4, "lset_rd");
    rd(BASE + 32'd8, "lclr_rd");
    wr(BASE + 32'd20, 32'h3FF, "lout_wr");
    rd(BASE, "lout_wr_chk");

    // blink P=3
    wr(BASE, 32'h3FF, "b3_data");
    wr(BASE + 32'd16, 32'd3, "b3_per");
    wr(BASE + 32'd12, 32'h001, "b3_mode");
    for (int i = 0; i < 14; i++) rd(BASE + 32'd20, "b3_lout");

    // P=5, then 0, then a mid-phase rewrite to 2
    wr(BASE + 32'd16, 32'd5, "b5_per");
    for (int i = 0; i < 7; i++) rd(BASE + 32'd20, "b5_lout");
    wr(BASE + 32'd16, 32'd0, "p0_per");
    for (int i = 0; i < 4; i++) rd(BASE + 32'd20, "p0_lout");
    wr(BASE + 32'd16, 32'd1, "p1_per");
    for (int i = 0; i < 3; i++) rd(BASE + 32'd20, "p1_lout");
    wr(BASE + 32'd16, 32'd2, "p2_per");
    for (int i = 0; i < 8; i++) rd(BASE + 32'd20, "p2_lout");

    // longest half-period
    wr(BASE + 32'd16, 32'hFFFF_FFFF, "pmax_per");
    rd(BASE + 32'd16, "pmax_rd");
    for (int i = 0; i < 4; i++) rd(BASE + 32'd20, "pmax_lout");

    // reset mid-blink overrides a same-cycle write
    wr(BASE + 32'd16, 32'd3, "rb_per");
    wr(BASE + 32'd12, 32'h3FF, "rb_mode");
    for (int i = 0; i < 4; i++) rd(BASE + 32'd20, "rb_lout");
    cycle(1'b1, 1'b1, BASE, 32'h155, "rb_rst");
    rd(BASE, "rb_ldata");
    rd(BASE + 32'd12, "rb_lmode");
    wr(BASE, 32'h2AA, "rb_data");
    wr(BASE + 32'd16, 32'd2, "rb_per2");
    wr(BASE + 32'd12, 32'h0F0, "rb_mode2");
    for (int i = 0; i < 6; i++) rd(BASE + 32'd20, "rb_blink");

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 8);
      if (sel == 8) a = BASE + 32'($urandom_range(1, 3));
      else          a = BASE + 32'(4 * sel);
      rnd = $urandom;
      d = rnd;
      if (a == BASE + 32'd16) begin
        if ($urandom_range(0, 9) == 0) d = {rnd[31:24], 24'hFFFFFF};
        else                           d = {rnd[31:24], 21'b0, 3'($urandom_range(0, 6))};
      end
      if ($urandom_range(0, 199) == 0)
        cycle(1'b1, 1'($urandom_range(0, 1)), a, d, "rnd_rst");
      else if ($urandom_range(0, 3) == 0)
        wr(a, d, "rnd_wr");
      else
        rd(a, "rnd_rd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
